// File: rtl/wr_arbiter_pkg.sv
// Shared constants and types for the write-port arbiter.
// Used by wr_arbiter, wr_arb_pick and wr_arbiter_if.
package wr_arbiter_pkg;

  localparam int NUM_REQ = 4;

  localparam logic [1:0] SCAN    = 2'd0;
  localparam logic [1:0] CTRL_I  = 2'd1;
  localparam logic [1:0] CTRL_II = 2'd2;
  localparam logic [1:0] GATE    = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } arb_state_t;

endpackage

// File: rtl/wr_arbiter_if.sv
// Request/grant bundle between the four writers and the write-port arbiter.
// The writers drive req/done; the arbiter drives the grant outputs.
interface wr_arbiter_if;
  import wr_arbiter_pkg::*;

  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] done;
  logic               select_scan;
  logic               select_control_i;
  logic               select_control_ii;
  logic               select_gate;
  logic [1:0]         owner;
  logic               busy;
  logic               timeout_err;

  modport master (
    output req, done,
    input  select_scan, select_control_i, select_control_ii, select_gate,
    input  owner, busy, timeout_err
  );

  modport slave (
    input  req, done,
    output select_scan, select_control_i, select_control_ii, select_gate,
    output owner, busy, timeout_err
  );
endinterface

// File: rtl/wr_arb_pick.sv
// Combinational 4-way picker: first set request at or after index start,
// wrapping modulo 4.
module wr_arb_pick
  import wr_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [1:0]         start,
  output logic               valid,
  output logic [1:0]         winner
);
  logic [NUM_REQ-1:0] rot;

  // rot[0] is the request at start, rot[1] the next one, and so on
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rot
      assign rot[gi] = req[2'(start + 2'(gi))];
    end
  endgenerate

  always_comb begin
    valid  = |rot;
    winner = start;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rot[i]) winner = start + 2'(i);
    end
  end
endmodule

// File: rtl/wr_arbiter.sv
// Write-port arbiter: IDLE/GRANT/GAP FSM with hold timeout and flush gap.
// Define WR_ARBITER_RR_EN for round-robin; default is fixed priority.
module wr_arbiter
  import wr_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYC = 1024,
  parameter int GAP_CYC     = 2
) (
  input  logic        clk,
  input  logic        reset,
  wr_arbiter_if.slave bus
);
  localparam int                HOLD_W      = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int                HOLD_LAST_I = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0;
  localparam logic [HOLD_W-1:0] HOLD_LAST   = HOLD_W'(HOLD_LAST_I);
  localparam logic [3:0]        GAP_LAST    = 4'(GAP_CYC - 1);

  arb_state_t          state_reg, state_next;
  logic [HOLD_W-1:0]   hold_reg, hold_next;
  logic [3:0]          gap_reg, gap_next;
  logic [NUM_REQ-1:0]  sel_reg, sel_next;
  logic [1:0]          owner_reg, owner_next;
  logic                busy_reg, busy_next;
  logic                tmo_reg, tmo_next;
  logic                armed_reg;
  logic [1:0]          start;
  logic                pick_valid;
  logic [1:0]          pick_winner;
  logic                rel;
  logic                timed_out;

`ifdef WR_ARBITER_RR_EN
  logic [1:0] ptr_reg, ptr_next;
  assign start = ptr_reg;
`else
  assign start = 2'd0;
`endif

  wr_arb_pick u_pick (
    .req    (bus.req),
    .start  (start),
    .valid  (pick_valid),
    .winner (pick_winner)
  );

  always_comb begin
    state_next = state_reg;
    hold_next  = hold_reg;
    gap_next   = gap_reg;
    sel_next   = sel_reg;
    owner_next = owner_reg;
    busy_next  = busy_reg;
    tmo_next   = 1'b0;
    rel        = 1'b0;
    timed_out  = 1'b0;
`ifdef WR_ARBITER_RR_EN
    ptr_next   = ptr_reg;
`endif
    case (state_reg)
      IDLE: begin
        // armed_reg holds off the first edge after reset release
        if (armed_reg && pick_valid) begin
          state_next = GRANT;
          sel_next   = 4'b0001 << pick_winner;
          owner_next = pick_winner;
          busy_next  = 1'b1;
          hold_next  = '0;
`ifdef WR_ARBITER_RR_EN
          ptr_next   = pick_winner + 2'd1;
`endif
        end
      end
      GRANT: begin
        rel       = bus.done[owner_reg] || !bus.req[owner_reg];
        timed_out = (TIMEOUT_CYC != 0) && (hold_reg == HOLD_LAST);
        if (rel || timed_out) begin
          state_next = GAP;
          sel_next   = '0;
          busy_next  = 1'b0;
          gap_next   = '0;
          tmo_next   = !rel;
        end else if (hold_reg != {HOLD_W{1'b1}}) begin
          hold_next = hold_reg + 1'b1;
        end
      end
      GAP: begin
        if (gap_reg == GAP_LAST) state_next = IDLE;
        else                     gap_next   = gap_reg + 4'd1;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      hold_reg  <= '0;
      gap_reg   <= '0;
      sel_reg   <= '0;
      owner_reg <= 2'd0;
      busy_reg  <= 1'b0;
      tmo_reg   <= 1'b0;
      armed_reg <= 1'b0;
`ifdef WR_ARBITER_RR_EN
      ptr_reg   <= 2'd0;
`endif
    end else begin
      state_reg <= state_next;
      hold_reg  <= hold_next;
      gap_reg   <= gap_next;
      sel_reg   <= sel_next;
      owner_reg <= owner_next;
      busy_reg  <= busy_next;
      tmo_reg   <= tmo_next;
      armed_reg <= 1'b1;
`ifdef WR_ARBITER_RR_EN
      ptr_reg   <= ptr_next;
`endif
    end
  end

  assign bus.select_scan       = sel_reg[SCAN];
  assign bus.select_control_i  = sel_reg[CTRL_I];
  assign bus.select_control_ii = sel_reg[CTRL_II];
  assign bus.select_gate       = sel_reg[GATE];
  assign bus.owner             = owner_reg;
  assign bus.busy              = busy_reg;
  assign bus.timeout_err       = tmo_reg;
endmodule

// File: tb/tb_wr_arbiter.sv
// Bench for wr_arbiter: directed scenarios plus random traffic, all checked
// every cycle against a grant-timeline reference model.
module tb_wr_arbiter;
  import wr_arbiter_pkg::*;

  localparam int TIMEOUT_CYC = 8;
  localparam int GAP_CYC     = 2;

  logic clk;
  logic rst;
  wr_arbiter_if bus ();

  wr_arbiter #(.TIMEOUT_CYC(TIMEOUT_CYC), .GAP_CYC(GAP_CYC)) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int errors = 0;
  int checks = 0;

  // Reference model: who holds the port, since which edge, and the earliest
  // edge at which a new grant may be issued.
  int   edge_n  = 0;
  bit   m_busy  = 0;
  int   m_owner = 0;
  int   m_start = 0;
  int   m_gedge = 0;
  int   m_allow = 0;
  bit   m_tmo   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h (edge %0d)", tag, obs, exp, edge_n);
    end
  endtask

  function automatic int pick(input logic [3:0] r, input int start);
    for (int i = 0; i < 4; i++) begin
      if (r[(start + i) % 4]) return (start + i) % 4;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_busy  = 0;
    m_owner = 0;
    m_start = 0;
    m_tmo   = 0;
  endtask

  task automatic model_edge();
    logic [3:0] r;
    logic [3:0] d;
    int w;
    r = bus.req;
    d = bus.done;
    if (!rst) begin
      model_reset();
      return;
    end
    m_tmo = 0;
    if (m_busy) begin
      if (d[m_owner] || !r[m_owner]) begin
        m_busy  = 0;
        m_allow = edge_n + GAP_CYC + 1;
      end else if (edge_n - m_gedge == TIMEOUT_CYC) begin
        m_busy  = 0;
        m_tmo   = 1;
        m_allow = edge_n + GAP_CYC + 1;
      end
    end else if (edge_n >= m_allow && r != 4'd0) begin
`ifdef WR_ARBITER_RR_EN
      w = pick(r, m_start);
`else
      w = pick(r, 0);
`endif
      m_busy  = 1;
      m_owner = w;
      m_gedge = edge_n;
      m_start = (w + 1) % 4;
    end
  endtask

  function automatic logic [3:0] dut_sel();
    return {bus.select_gate, bus.select_control_ii, bus.select_control_i, bus.select_scan};
  endfunction

  task automatic check_all();
    logic [3:0] s;
    s = dut_sel();
    chk("select", s, m_busy ? (4'b0001 << m_owner) : 4'b0000);
    chk("busy", bus.busy, m_busy);
    chk("owner", bus.owner, m_owner[1:0]);
    chk("timeout_err", bus.timeout_err, m_tmo);
    chk("onehot", $onehot0(s), 1);
    chk("busy_or", bus.busy, |s);
  endtask

  // One clock: inputs were set on the preceding negedge.
  task automatic step();
    @(posedge clk);
    edge_n++;
    model_edge();
    #1;
    check_all();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    bus.req  = 4'd0;
    bus.done = 4'd0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_busy(input string tag);
    int n = 0;
    while (!bus.busy && n < 20) begin
      step();
      n++;
    end
    chk(tag, bus.busy, 1);
  endtask

  initial begin
    int exp_order [5];
    int cnt;
    rst      = 1'b0;
    bus.req  = 4'd0;
    bus.done = 4'd0;
    #1;
    chk("rst_select", dut_sel(), 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_owner", bus.owner, 0);
    chk("rst_tmo", bus.timeout_err, 0);
    @(negedge clk);
    step();
    step();
    rst     = 1'b1;
    m_allow = edge_n + 2;

    // Grant order with all four requesting
`ifdef WR_ARBITER_RR_EN
    exp_order = '{0, 1, 2, 3, 0};
`else
    exp_order = '{0, 0, 0, 0, 0};
`endif
    bus.req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_busy("order_grant");
      chk("order_owner", bus.owner, exp_order[k][1:0]);
      bus.done = 4'b0001 << m_owner;
      step();
      bus.done = 4'd0;
    end
    idle(5);

    // control_i granted, released by done, then control_ii after the gap
    bus.req = 4'b0110;
    step();
    chk("ci_select", bus.select_control_i, 1);
    chk("ci_owner", bus.owner, 1);
    bus.done = 4'b0010;
    bus.req  = 4'b0100;
    step();
    bus.done = 4'd0;
    chk("ci_release", dut_sel(), 0);
    step();
    step();
    chk("gap_low", dut_sel(), 0);
    step();
    chk("cii_select", bus.select_control_ii, 1);
    bus.done = 4'b0100;
    step();
    idle(5);

    // A foreign done must not disturb the scan grant
    bus.req = 4'b0001;
    step();
    chk("scan_grant", bus.select_scan, 1);
    bus.req  = 4'b0101;
    bus.done = 4'b0100;
    step();
    bus.done = 4'd0;
    chk("foreign_done_owner", bus.owner, 0);
    chk("foreign_done_sel", bus.select_scan, 1);
    idle(5);

    // Timeout: gate held without done
    bus.req = 4'b1000;
    step();
    chk("gate_grant", bus.select_gate, 1);
    cnt = 1;
    while (bus.select_gate && cnt < 20) begin
      step();
      if (bus.select_gate) cnt++;
    end
    chk("tmo_len", cnt, TIMEOUT_CYC);
    chk("tmo_pulse", bus.timeout_err, 1);
    bus.req = 4'd0;
    step();
    chk("tmo_single", bus.timeout_err, 0);
    idle(4);

    // Asynchronous reset in the middle of a grant
    bus.req = 4'b0001;
    step();
    step();
    step();
    step();
    chk("pre_rst_grant", bus.select_scan, 1);
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    chk("async_rst_sel", dut_sel(), 0);
    chk("async_rst_busy", bus.busy, 0);
    chk("async_rst_tmo", bus.timeout_err, 0);
    @(negedge clk);
    step();
    step();
    rst     = 1'b1;
    m_allow = edge_n + 2;
    step();
    chk("post_rst_edge1", bus.select_scan, 0);
    step();
    chk("post_rst_edge2", bus.select_scan, 1);
    idle(4);

    // Random traffic
    for (int c = 0; c < 800; c++) begin
      int r;
      logic [3:0] q;
      q = bus.req;
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(0, 7) == 0) q[b] = ~q[b];
      end
      bus.req = q;
      r = $urandom_range(0, 9);
      if (r < 2)       bus.done = 4'b0001 << m_owner;
      else if (r == 2) bus.done = 4'($urandom_range(0, 15));
      else             bus.done = 4'd0;
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/wr_arbiter.md
WR_ARBITER -- requirements
Module: wr_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYC, default 1024: max cycles a requester may hold the write port before forced release; 0 disables the timeout.
REQ-002 Parameter GAP_CYC, default 2, range 1..15: idle cycles between release and next grant, covering the registered write-mux flush.
REQ-003 clk  in  1  single clock, all logic rising-edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 req  in  4  request per writer: [0] scan, [1] control_i, [2] control_ii, [3] gate.
REQ-006 done  in  4  per-writer release strobe, one-cycle pulse, same index order.
REQ-007 select_scan, select_control_i, select_control_ii, select_gate  out  1 each  registered one-hot grant, drives the write-mux selects.
REQ-008 owner  out  2  index of current grantee, valid while busy=1.
REQ-009 busy  out  1  high in GRANT state.
REQ-010 timeout_err  out  1  one-cycle pulse on forced release.

Function
REQ-011 FSM states IDLE, GRANT, GAP; state and all outputs registered.
REQ-012 IDLE: if any req bit set, pick a winner, assert its select next cycle, go to GRANT; else stay.
REQ-013 Grant latency: req sampled high in IDLE -> select high on the following clock edge (1 cycle).
REQ-014 At most one select high at any time; all selects low in IDLE and GAP.
REQ-015 GRANT: hold owner until done[owner]=1 or req[owner]=0, then deassert select next cycle and go to GAP.
REQ-016 done or req changes from non-owners are ignored in GRANT; done while IDLE or GAP is ignored.
REQ-017 Hold counter: 0 on grant, +1 per GRANT cycle, saturates; reaching TIMEOUT_CYC-1 with no release forces GAP and pulses timeout_err with select deassertion.
REQ-018 Release and timeout on the same cycle: treat as normal release, no timeout_err.
REQ-019 GAP: count GAP_CYC cycles with selects low, then IDLE; a new grant is at the earliest GAP_CYC+1 cycles after the select falls.
REQ-020 Fixed-priority mode: scan > control_i > control_ii > gate.
REQ-021 owner updates with the select edge and holds its last value while idle.

Reset
REQ-022 reset low: state IDLE, all selects 0, owner 0, busy 0, timeout_err 0, counters 0, round-robin pointer 0, immediately and asynchronously.
REQ-023 reset asserted mid-GRANT drops the select asynchronously; no timeout_err.
REQ-024 First grant is possible on the second rising edge after reset release.

Configuration
REQ-025 Macro WR_ARBITER_RR_EN defined: round-robin arbitration; search starts at index last_owner+1 mod 4, and the pointer updates on each grant.
REQ-026 WR_ARBITER_RR_EN undefined: fixed priority per REQ-020; no pointer register.

Structure
REQ-027 Package wr_arbiter_pkg holds: requester index constants (SCAN=0, CTRL_I=1, CTRL_II=2, GATE=3), the 2-bit FSM state type, NUM_REQ=4.
REQ-028 One sub-module, wr_arb_pick: combinational 4-way picker taking req and start index, returning valid and winner index; fixed mode ties start to 0.

Verification
REQ-029 req=4'b0110 in IDLE -> select_control_i=1 one cycle later, owner=1; done[1] pulse -> select low next cycle, 2 GAP cycles, then select_control_ii=1.
REQ-030 WR_ARBITER_RR_EN, req=4'b1111 held, owner pulses done each grant -> grants in order 0,1,2,3,0 with GAP_CYC gaps; without the macro -> scan granted every time.
REQ-031 TIMEOUT_CYC=8, req[3] held, no done -> select_gate high exactly 8 cycles, timeout_err single pulse, select falls on the same edge.
REQ-032 done[2] pulsed while scan owns the grant -> no change to grant or owner.
REQ-033 reset driven low 3 cycles into a grant -> all selects 0 without waiting for a clk edge; after release, req=4'b0001 -> select_scan on the second edge.
REQ-034 Every cycle: selects at most one-hot; busy equals OR of selects.
